pow3_stream_ctrl: RTL

POW3_STREAM_CTRL -- requirements
Module: pow3_stream_ctrl

---
 rtl/pow3_pkg.sv | 12 +
 rtl/pow3_result_fifo.sv | 61 ++++++
 rtl/pow3_stream_ctrl.sv | 98 +++++++++
 3 files changed

// File: rtl/pow3_pkg.sv
// Shared defaults and result-entry payload for the power-of-3 stream controller.
package pow3_pkg;

   localparam int unsigned POW3_DATA_W      = 32;
   localparam int unsigned POW3_CHK_LATENCY = 4;

   typedef struct packed {
      logic [POW3_DATA_W-1:0] data;
      logic                   ispow3;
   } pow3_entry_t;

endpackage

// File: rtl/pow3_result_fifo.sv
// Synchronous result FIFO with occupancy count; pointers wrap modulo DEPTH (power of two).
module pow3_result_fifo
   import pow3_pkg::*;
#(
   parameter int unsigned DEPTH   = 8,
   parameter type         entry_t = pow3_entry_t,
   localparam int unsigned AW     = $clog2(DEPTH),
   localparam int unsigned CW     = $clog2(DEPTH + 1)
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          wr_i,
   input  entry_t        wr_data_i,
   input  logic          rd_i,
   output entry_t        rd_data_o,
   output logic [CW-1:0] count_o
);

   entry_t        mem_q [DEPTH];
   logic [AW-1:0] wr_ptr_q, wr_ptr_d;
   logic [AW-1:0] rd_ptr_q, rd_ptr_d;
   logic [CW-1:0] count_q, count_d;
   logic          rd_eff;

   assign rd_eff    = rd_i && (count_q != '0);
   assign rd_data_o = mem_q[rd_ptr_q];
   assign count_o   = count_q;

   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q + CW'(wr_i) - CW'(rd_eff);
      if (wr_i)   wr_ptr_d = AW'(wr_ptr_q + AW'(1));
      if (rd_eff) rd_ptr_d = AW'(rd_ptr_q + AW'(1));
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

   // Storage is deliberately left unreset.
   always_ff @(posedge clk) begin
      if (wr_i) mem_q[wr_ptr_q] <= wr_data_i;
   end

   always @(posedge clk) begin
      if (rst_n) begin
         assert (!(wr_i && (count_q == CW'(DEPTH))))
            else $error("pow3_result_fifo: write into full buffer");
      end
   end

endmodule

// File: rtl/pow3_stream_ctrl.sv
// Streams numbers through an external fixed-latency power-of-3 checker and buffers
// {number, flag} results in order, with credit-based backpressure toward upstream.
module pow3_stream_ctrl
   import pow3_pkg::*;
#(
   parameter int unsigned DATA_W      = POW3_DATA_W,
   parameter int unsigned CHK_LATENCY = POW3_CHK_LATENCY,
   parameter int unsigned FIFO_DEPTH  = 8
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [DATA_W-1:0] in_data,
   output logic [DATA_W-1:0] chk_n,
   input  logic              chk_ispow3,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [DATA_W-1:0] out_data,
   output logic              out_ispow3,
   output logic [31:0]       pow3_count
);

   localparam int unsigned IW = $clog2(CHK_LATENCY + 1);
   localparam int unsigned FW = $clog2(FIFO_DEPTH + 1);
   localparam int unsigned SW = $clog2(FIFO_DEPTH + CHK_LATENCY + 1);

   typedef struct packed {
      logic [DATA_W-1:0] data;
      logic              ispow3;
   } entry_t;

   logic                   accept;
   logic                   tail;
   logic                   pop;
   logic [CHK_LATENCY-1:0] vld_q, vld_d;
   logic [DATA_W-1:0]      dat_q [CHK_LATENCY];
   logic [IW-1:0]          inflight_q, inflight_d;
   logic [FW-1:0]          fifo_count;
   logic [31:0]            pow3_count_q, pow3_count_d;
   entry_t                 wr_entry;
   entry_t                 head;

   // Credits cover both buffered and in-flight results, so the buffer can never overflow.
   assign in_ready = (SW'(fifo_count) + SW'(inflight_q)) < SW'(FIFO_DEPTH);
   assign accept   = in_valid & in_ready & rst_n;
   assign chk_n    = accept ? in_data : '0;
   assign tail     = vld_q[CHK_LATENCY-1];

   assign out_valid  = (fifo_count != '0);
   assign out_data   = out_valid ? head.data : '0;
   assign out_ispow3 = out_valid & head.ispow3;
   assign pop        = out_valid & out_ready;
   assign pow3_count = pow3_count_q;

   always_comb begin
      vld_d    = '0;
      vld_d[0] = accept;
      for (int i = 1; i < int'(CHK_LATENCY); i++) vld_d[i] = vld_q[i-1];
      inflight_d   = inflight_q + IW'(accept) - IW'(tail);
      pow3_count_d = pow3_count_q;
      if (pop && out_ispow3 && (pow3_count_q != '1)) pow3_count_d = pow3_count_q + 32'd1;
      wr_entry.data   = dat_q[CHK_LATENCY-1];
      wr_entry.ispow3 = chk_ispow3;
   end

   // Clearing the valid line on reset drops checker results still in flight.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         vld_q        <= '0;
         inflight_q   <= '0;
         pow3_count_q <= '0;
      end else begin
         vld_q        <= vld_d;
         inflight_q   <= inflight_d;
         pow3_count_q <= pow3_count_d;
      end
   end

   always_ff @(posedge clk) begin
      dat_q[0] <= in_data;
      for (int i = 1; i < int'(CHK_LATENCY); i++) dat_q[i] <= dat_q[i-1];
   end

   pow3_result_fifo #(
      .DEPTH   (FIFO_DEPTH),
      .entry_t (entry_t)
   ) u_fifo (
      .clk       (clk),
      .rst_n     (rst_n),
      .wr_i      (tail),
      .wr_data_i (wr_entry),
      .rd_i      (pop),
      .rd_data_o (head),
      .count_o   (fifo_count)
   );

endmodule
